iob_iob2wishbone_bridge: RTL and testbench
==========================================

// Module: iob_iob2wishbone_bridge
// PURPOSE
//  Parametrised IOb-native to Wishbone B4 master bridge. Classic and pipelined (stall) modes.
//  Registered request path, bus-timeout watchdog and error reporting back to the IOb side.
//  Sits between a CPU/DMA IOb port and Wishbone peripherals such as the Ethernet MAC register and buffer space.
// PARAMETERS
//  ADDR_W     32  address width, IOb and Wishbone
//  DATA_W     32  data width; must be a multiple of 8 (elaboration $error otherwise)
//  PIPELINED  0   0 = Wishbone classic (stb held until ack); 1 = B4 pipelined (stb held until !stall)
//  TIMEOUT    256 cycles to wait for ack/err before an internal abort; 0 = watchdog disabled
// PORTS
//  clk_i        in   1         clock; all logic on rising edge
//  rst_n_i      in   1         reset, synchronous, active-low
//  valid_i      in   1         IOb request strobe; single-cycle pulse is sufficient
//  address_i    in   ADDR_W    IOb byte address
//  wdata_i      in   DATA_W    IOb write data
//  wstrb_i      in   DATA_W/8  IOb byte strobes; all-zero = read
//  rdata_o      out  DATA_W    read data, valid while ready_o=1
//  ready_o      out  1         one-cycle completion pulse
//  error_o      out  1         qualifies ready_o: transaction ended with wb_err_i or timeout
//  timeout_o    out  1         qualifies ready_o: the error was a watchdog abort
//  wb_adr_o     out  ADDR_W    Wishbone address
//  wb_sel_o     out  DATA_W/8  byte select
//  wb_we_o      out  1         write enable
//  wb_cyc_o     out  1         bus cycle
//  wb_stb_o     out  1         strobe
//  wb_dat_o     out  DATA_W    write data
//  wb_ack_i     in   1         acknowledge
//  wb_err_i     in   1         bus error
//  wb_stall_i   in   1         pipelined stall; ignored when PIPELINED=0
//  wb_dat_i     in   DATA_W    read data
// BEHAVIOUR
//  - Reset (rst_n_i=0 at an edge): state IDLE, watchdog counter 0, every output 0.
//    Reset mid-transaction drops cyc/stb at that edge and produces no ready_o.
//  - FSM states: IDLE, REQ, WAIT, DONE. All Wishbone outputs are registered.
//  - IDLE: valid_i=1 captures the request and goes to REQ.
//      adr <= address_i; dat <= wdata_i; we <= |wstrb_i
//      sel <= write ? wstrb_i : all-ones (DATA_W/8 bits)
//  - REQ: cyc=stb=1.
//      PIPELINED=0: stay until ack|err|timeout, then DONE.
//      PIPELINED=1: stall=0 accepts the request -> WAIT (stb=0); ack|err in the accept cycle -> DONE directly.
//  - WAIT: cyc=1, stb=0 until ack|err|timeout, then DONE.
//  - Leaving REQ/WAIT drops cyc and stb in the same edge.
//  - Response capture on leaving REQ/WAIT:
//      rdata <= ack ? wb_dat_i : 0
//      error <= err | timeout
//      timeout_o <= timeout & !ack & !err
//      ack and err in the same cycle: err wins (error=1, rdata=0).
//  - DONE: ready_o=1 for exactly one cycle; rdata_o, error_o and timeout_o are valid here and zero otherwise.
//      valid_i=1 in DONE is captured as a back-to-back request (-> REQ); otherwise -> IDLE.
//  - valid_i in REQ/WAIT is ignored; the IOb master must not re-issue before ready_o.
//  - Latency: valid cycle 0, stb cycle 1, earliest ack cycle 1, ready_o cycle 2. Peak rate is one transaction per 2 cycles.
//  - Watchdog: clears on entry to REQ and increments each REQ/WAIT cycle.
//      Count == TIMEOUT-1 with no ack/err -> abort to DONE.
//      Width is $clog2(TIMEOUT+1). Saturates, never wraps. TIMEOUT=0 disables it.
//  - ack/err while cyc=0 (late response after an abort) is ignored; no state or output change.
// STRUCTURE
//  - Shared header iob2wb_defs.vh: state encodings (2-bit), mode constants CLASSIC/PIPELINED.
//  - One sub-module: iob2wb_watchdog (clear, enable, TIMEOUT param, expired output).
//  - Request/response registers and the FSM stay in this module.
// TESTING
//  1. Classic read, DATA_W=32: valid @adr 0x40, wstrb=0, slave acks 1 cycle later with 0xDEADBEEF
//     -> sel=0xF, we=0, ready_o once, rdata_o=0xDEADBEEF, error_o=0.
//  2. Pipelined write, wstrb=0x3, stall=1 for 3 cycles, ack 2 cycles after accept
//     -> stb high exactly 4 cycles, cyc held until ack, sel=0x3, one ready_o.
//  3. Error: slave asserts ack and err together -> ready_o=1, error_o=1, timeout_o=0, rdata_o=0.
//  4. Timeout: TIMEOUT=8, slave silent -> cyc drops after 8 cycles, ready_o with error_o=timeout_o=1.
//     A late ack 2 cycles later causes no second ready_o.
//  5. Back-to-back: valid_i asserted in the DONE cycle -> new stb the next cycle, two ready_o pulses, no request lost.
//  6. Reset mid-WAIT: rst_n_i=0 one cycle -> cyc/stb/ready_o all 0 at that edge, FSM IDLE.
//     A fresh read then completes normally.

Source files
------------

// File: rtl/iob_iob2wishbone_bridge_pkg.sv
// rtl/iob_iob2wishbone_bridge_pkg.sv - shared state encoding, mode constants and helpers for the IOb to Wishbone bridge
package iob_iob2wishbone_bridge_pkg;

  // Bridge FSM states, 2-bit encoded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Wishbone handshake flavours selected by the PIPELINED parameter
  localparam int MODE_CLASSIC   = 0;
  localparam int MODE_PIPELINED = 1;

  // Watchdog counter width; a disabled watchdog still keeps a 1-bit register
  function automatic int wd_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/iob_iob2wishbone_bridge_watchdog.sv
// rtl/iob_iob2wishbone_bridge_watchdog.sv - bus-timeout watchdog for the IOb to Wishbone bridge
module iob_iob2wishbone_bridge_watchdog
  import iob_iob2wishbone_bridge_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = wd_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(TIMEOUT);
  localparam bit ACTIVE = (TIMEOUT > 0);

  logic [CNT_W-1:0] count;

  // Cycle counter: cleared when a request starts, counts bus cycles, saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TOP)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = ACTIVE && enable && (count == LAST);

endmodule

// File: rtl/iob_iob2wishbone_bridge.sv
// rtl/iob_iob2wishbone_bridge.sv - IOb native to Wishbone B4 master bridge, classic or pipelined, with watchdog
module iob_iob2wishbone_bridge
  import iob_iob2wishbone_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PIPELINED = 0,
  parameter int TIMEOUT   = 256
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                error_o,
  output logic                timeout_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_stall_i,
  input  logic [DATA_W-1:0]   wb_dat_i
);

  generate
    if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("iob_iob2wishbone_bridge: DATA_W must be a multiple of 8");
    end
    if ((PIPELINED != MODE_CLASSIC) && (PIPELINED != MODE_PIPELINED)) begin : g_bad_mode
      $error("iob_iob2wishbone_bridge: PIPELINED must be 0 or 1");
    end
  endgenerate

  localparam bit PIPE = (PIPELINED == MODE_PIPELINED);

  state_t state;
  logic   busy;
  logic   start;
  logic   expired;
  logic   finish;
  logic   hit_timeout;

  assign busy        = (state == ST_REQ) || (state == ST_WAIT);
  assign start       = valid_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign finish      = busy && (wb_ack_i || wb_err_i || expired);
  assign hit_timeout = expired && !wb_ack_i && !wb_err_i;

  iob_iob2wishbone_bridge_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .clear  (start),
    .enable (busy),
    .expired(expired)
  );

  // Request/response FSM; every Wishbone and IOb output is a register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      rdata_o   <= '0;
      ready_o   <= 1'b0;
      error_o   <= 1'b0;
      timeout_o <= 1'b0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_dat_o  <= '0;
    end else if (finish) begin
      // Response, error or abort: release the bus and report in the same edge; err beats ack
      state     <= ST_DONE;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      ready_o   <= 1'b1;
      rdata_o   <= (wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
      error_o   <= wb_err_i || hit_timeout;
      timeout_o <= hit_timeout;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          ready_o   <= 1'b0;
          rdata_o   <= '0;
          error_o   <= 1'b0;
          timeout_o <= 1'b0;
          if (valid_i) begin
            state    <= ST_REQ;
            wb_adr_o <= address_i;
            wb_dat_o <= wdata_i;
            wb_we_o  <= |wstrb_i;
            wb_sel_o <= (|wstrb_i) ? wstrb_i : '1;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // Pipelined slaves take the request on the first non-stalled cycle
          if (PIPE && !wb_stall_i) begin
            state    <= ST_WAIT;
            wb_stb_o <= 1'b0;
          end
        end
        ST_WAIT: begin
          state <= ST_WAIT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_iob2wishbone_bridge.sv
// tb/tb_iob_iob2wishbone_bridge.sv - randomized self-checking bench for the IOb to Wishbone bridge
module tb_iob_iob2wishbone_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;
  localparam int NRAND = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: classic bridge, index 1: pipelined bridge
  logic [1:0]    rst_n, valid, ready, error, tmo;
  logic [1:0]    wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_stall;
  logic [AW-1:0] address [2];
  logic [AW-1:0] wb_adr  [2];
  logic [DW-1:0] wdata   [2];
  logic [DW-1:0] rdata   [2];
  logic [DW-1:0] wb_dout [2];
  logic [DW-1:0] wb_din  [2];
  logic [SW-1:0] wstrb   [2];
  logic [SW-1:0] wb_sel  [2];

  iob_iob2wishbone_bridge #(.ADDR_W(AW), .DATA_W(DW), .PIPELINED(0), .TIMEOUT(TO)) u_classic (
    .clk_i(clk), .rst_n_i(rst_n[0]), .valid_i(valid[0]), .address_i(address[0]),
    .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .rdata_o(rdata[0]), .ready_o(ready[0]),
    .error_o(error[0]), .timeout_o(tmo[0]), .wb_adr_o(wb_adr[0]), .wb_sel_o(wb_sel[0]),
    .wb_we_o(wb_we[0]), .wb_cyc_o(wb_cyc[0]), .wb_stb_o(wb_stb[0]), .wb_dat_o(wb_dout[0]),
    .wb_ack_i(wb_ack[0]), .wb_err_i(wb_err[0]), .wb_stall_i(wb_stall[0]), .wb_dat_i(wb_din[0])
  );

  iob_iob2wishbone_bridge #(.ADDR_W(AW), .DATA_W(DW), .PIPELINED(1), .TIMEOUT(TO)) u_pipe (
    .clk_i(clk), .rst_n_i(rst_n[1]), .valid_i(valid[1]), .address_i(address[1]),
    .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .rdata_o(rdata[1]), .ready_o(ready[1]),
    .error_o(error[1]), .timeout_o(tmo[1]), .wb_adr_o(wb_adr[1]), .wb_sel_o(wb_sel[1]),
    .wb_we_o(wb_we[1]), .wb_cyc_o(wb_cyc[1]), .wb_stb_o(wb_stb[1]), .wb_dat_o(wb_dout[1]),
    .wb_ack_i(wb_ack[1]), .wb_err_i(wb_err[1]), .wb_stall_i(wb_stall[1]), .wb_dat_i(wb_din[1])
  );

  // One transaction as the slave will play it: cycle-numbered, independent of the DUT
  typedef struct {
    int          dut;
    int          t0;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
    logic [3:0]  wstrb;
    int          stall_n;
    int          delay;
    bit          ack;
    bit          err;
    int          rst_at;
  } plan_t;

  typedef struct packed {
    logic        cyc, stb, ready, error, tmo, we;
    logic [31:0] rdata, adr, dat;
    logic [3:0]  sel;
  } exp_t;

  plan_t plans[$];
  int    cur = 4;
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc_n = 0;
  bit    run_chk = 1'b0;
  int    n_ready [2] = '{0, 0};
  int    exp_ready [2] = '{0, 0};

  function automatic int accept_c(input plan_t p);
    return p.t0 + 1 + ((p.dut == 1) ? p.stall_n : 0);
  endfunction

  function automatic int resp_c(input plan_t p);
    return accept_c(p) + p.delay;
  endfunction

  function automatic bit timed_out(input plan_t p);
    return !(p.ack || p.err) || (resp_c(p) > p.t0 + TO);
  endfunction

  function automatic int end_c(input plan_t p);
    return timed_out(p) ? p.t0 + TO : resp_c(p);
  endfunction

  // Expected outputs of plan p's DUT during cycle c (all zero outside the transaction)
  function automatic exp_t model(input plan_t p, input int c);
    exp_t e;
    int   te;
    int   last;
    e    = '0;
    te   = end_c(p);
    last = (p.rst_at > 0) ? p.rst_at : te + 1;
    if (c < p.t0 + 1 || c > last) return e;
    e.cyc   = (c <= te);
    e.stb   = e.cyc && (p.dut == 0 || c <= accept_c(p));
    e.ready = (c == te + 1);
    e.error = e.ready && (timed_out(p) || p.err);
    e.tmo   = e.ready && timed_out(p);
    e.rdata = (e.ready && !timed_out(p) && p.ack && !p.err) ? p.rdat : 32'h0;
    e.adr   = p.addr;
    e.dat   = p.wdata;
    e.we    = (p.wstrb != 4'h0);
    e.sel   = e.we ? p.wstrb : 4'hF;
    return e;
  endfunction

  function automatic exp_t expect_at(input int d, input int c);
    exp_t e;
    e = '0;
    foreach (plans[i]) begin
      exp_t m;
      if (plans[i].dut == d) begin
        m = model(plans[i], c);
        if (m.cyc || m.ready) e = m;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input int d, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, c, act, exp);
  endtask

  task automatic add_plan(input int dut, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input int stall_n, input int delay, input bit ack, input bit err,
                          input bit b2b, input bit do_rst, input logic [31:0] rdat);
    plan_t p;
    int    te;
    int    tr;
    p.dut = dut; p.t0 = cur; p.addr = addr; p.wdata = wd; p.wstrb = ws; p.rdat = rdat;
    p.stall_n = stall_n; p.delay = delay; p.ack = ack; p.err = err;
    p.rst_at = do_rst ? cur + 3 : 0;
    plans.push_back(p);
    te = end_c(p);
    tr = resp_c(p);
    if (!do_rst) exp_ready[dut]++;
    if (do_rst) cur = ((tr > p.rst_at) ? tr : p.rst_at) + 2;
    else if (b2b && !timed_out(p)) cur = te + 1;
    else cur = ((tr + 1 > te + 1) ? tr + 1 : te + 1) + int'($urandom_range(1, 3));
  endtask

  // Inputs for cycle c: IOb requests from the plans, slave replies at the planned cycles
  task automatic drive(input int c);
    for (int d = 0; d < 2; d++) begin
      valid[d]    = 1'b0;
      address[d]  = $urandom;
      wdata[d]    = $urandom;
      wstrb[d]    = 4'($urandom);
      wb_ack[d]   = 1'b0;
      wb_err[d]   = 1'b0;
      wb_stall[d] = 1'($urandom);
      wb_din[d]   = $urandom;
      rst_n[d]    = (c >= 2);
      foreach (plans[i]) begin
        if (plans[i].dut == d) begin
          if (c == plans[i].t0) begin
            valid[d] = 1'b1; address[d] = plans[i].addr; wdata[d] = plans[i].wdata; wstrb[d] = plans[i].wstrb;
          end
          if (d == 1 && c >= plans[i].t0 + 1 && c < accept_c(plans[i])) wb_stall[d] = 1'b1;
          if (d == 1 && c == accept_c(plans[i])) wb_stall[d] = 1'b0;
          if (c == resp_c(plans[i])) begin
            wb_ack[d] = plans[i].ack; wb_err[d] = plans[i].err; wb_din[d] = plans[i].rdat;
          end
          if (c == plans[i].rst_at) rst_n[d] = 1'b0;
        end
      end
    end
  endtask

  // Compare both bridges against the model on every cycle
  always @(negedge clk) begin
    if (run_chk && cyc_n >= 1) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        e = expect_at(d, cyc_n);
        if (ready[d] === 1'b1) n_ready[d]++;
        chk("cyc",     d, cyc_n, 32'(wb_cyc[d]), 32'(e.cyc));
        chk("stb",     d, cyc_n, 32'(wb_stb[d]), 32'(e.stb));
        chk("ready",   d, cyc_n, 32'(ready[d]),  32'(e.ready));
        chk("error",   d, cyc_n, 32'(error[d]),  32'(e.error));
        chk("timeout", d, cyc_n, 32'(tmo[d]),    32'(e.tmo));
        chk("rdata",   d, cyc_n, rdata[d],       e.rdata);
        if (e.cyc) begin
          chk("adr", d, cyc_n, wb_adr[d],        e.adr);
          chk("dat", d, cyc_n, wb_dout[d],       e.dat);
          chk("we",  d, cyc_n, 32'(wb_we[d]),    32'(e.we));
          chk("sel", d, cyc_n, 32'(wb_sel[d]),   32'(e.sel));
        end
      end
    end
  end

  initial begin
    int   last;
    int   nstb;
    exp_t m;
    plan_t p;

    // Directed scenarios
    add_plan(0, 32'h40, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF);           // 0 classic read
    add_plan(1, 32'h104, 32'h1234_5678, 4'h3, 3, 2, 1, 0, 0, 0, 32'h0);         // 1 pipelined stalled write
    add_plan(0, 32'h200, 32'h0, 4'h0, 0, 1, 1, 1, 0, 0, 32'hCAFE_F00D);         // 2 ack and err together
    add_plan(0, 32'h300, 32'h0, 4'h0, 0, 9, 1, 0, 0, 0, 32'h5555_AAAA);         // 3 timeout then late ack
    add_plan(1, 32'h304, 32'h0, 4'h0, 20, 0, 0, 0, 0, 0, 32'h0);                // 4 timeout while stalled
    add_plan(0, 32'h400, 32'hA5A5_A5A5, 4'hF, 0, 0, 1, 0, 1, 0, 32'h0);         // 5 back-to-back first
    add_plan(0, 32'h404, 32'h0, 4'h0, 0, 1, 1, 0, 0, 0, 32'h0BAD_CAFE);         // 6 back-to-back second
    add_plan(1, 32'h500, 32'h0, 4'h0, 0, 5, 1, 0, 0, 1, 32'h1111_2222);         // 7 reset mid-WAIT
    add_plan(1, 32'h504, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 32'h3333_4444);         // 8 fresh read after reset
    for (int i = 0; i < NRAND; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      add_plan(int'($urandom_range(0, 1)), $urandom, $urandom,
               ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 9)),
               (k >= 2), (k == 1 || k == 2), ($urandom_range(0, 9) < 4), 1'b0, $urandom);
    end

    // Literal expectations pinning the model to the scenarios
    p = plans[0];
    m = model(p, p.t0 + 1);
    chk("pin_read_sel", 0, p.t0 + 1, 32'(m.sel), 32'hF);
    chk("pin_read_stb", 0, p.t0 + 1, 32'(m.stb), 32'h1);
    m = model(p, p.t0 + 2);
    chk("pin_read_ready", 0, p.t0 + 2, 32'(m.ready), 32'h1);
    chk("pin_read_rdata", 0, p.t0 + 2, m.rdata, 32'hDEADBEEF);
    chk("pin_read_error", 0, p.t0 + 2, 32'(m.error), 32'h0);
    p = plans[1];
    nstb = 0;
    for (int c = p.t0; c < p.t0 + 12; c++) begin
      m = model(p, c);
      nstb += int'(m.stb);
    end
    chk("pin_stall_stb_cycles", 1, p.t0, 32'(nstb), 32'd4);
    m = model(p, p.t0 + 6);
    chk("pin_stall_cyc_at_ack", 1, p.t0 + 6, 32'(m.cyc), 32'h1);
    m = model(p, p.t0 + 7);
    chk("pin_stall_ready", 1, p.t0 + 7, 32'(m.ready), 32'h1);
    p = plans[2];
    m = model(p, p.t0 + 3);
    chk("pin_err_wins", 0, p.t0 + 3, {m.rdata[27:0], m.ready, m.error, m.tmo, 1'b0}, 32'h0000_000C);
    p = plans[3];
    m = model(p, p.t0 + 8);
    chk("pin_to_cyc_last", 0, p.t0 + 8, 32'(m.cyc), 32'h1);
    m = model(p, p.t0 + 9);
    chk("pin_to_flags", 0, p.t0 + 9, {28'h0, m.cyc, m.ready, m.error, m.tmo}, 32'h7);
    m = model(p, p.t0 + 11);
    chk("pin_to_no_second_ready", 0, p.t0 + 11, 32'(m.ready), 32'h0);
    chk("pin_b2b_start", 0, plans[6].t0, 32'(plans[6].t0), 32'(plans[5].t0 + 2));
    p = plans[7];
    m = model(p, p.rst_at + 1);
    chk("pin_reset_drop", 1, p.rst_at + 1, {30'h0, m.cyc, m.ready}, 32'h0);

    // Cycle-by-cycle run
    drive(0);
    cyc_n   = 0;
    run_chk = 1'b1;
    last    = cur + 20;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      cyc_n = c;
      drive(c);
    end
    @(negedge clk);
    #1;
    run_chk = 1'b0;
    chk("ready_count", 0, cyc_n, 32'(n_ready[0]), 32'(exp_ready[0]));
    chk("ready_count", 1, cyc_n, 32'(n_ready[1]), 32'(exp_ready[1]));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
